handshake_serializer: RTL and testbench
=======================================

HANDSHAKE_SERIALIZER -- requirements
Module: handshake_serializer

Interface
REQ-001 Parameter IN_W, default 16, input word width in bits.
REQ-002 Parameter OUT_W, default 8, output slice width; IN_W SHALL be an integer multiple of OUT_W, with N = IN_W/OUT_W >= 2 (elaboration error otherwise).
REQ-003 Parameter MSB_FIRST, default 1: 1 = most-significant slice sent first, 0 = least-significant first.
REQ-004 Parameter BUBBLE, default 0: 1 = one idle cycle with ready_out low between slices (legacy pacing); 0 = no gap.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 ready_in  input  1  upstream has a valid word on data_in; held high until accepted_out is seen.
REQ-009 data_in  input  IN_W  upstream word; stable while ready_in is high.
REQ-010 accepted_out  output  1  one-cycle pulse: word captured.
REQ-011 ready_out  output  1  data_out holds a valid slice.
REQ-012 data_out  output  OUT_W  current slice.
REQ-013 last_out  output  1  ready_out high and the current slice is slice N-1 of the word.
REQ-014 slice_idx  output  $clog2(N)  index of the current slice in transmission order.
REQ-015 accepted_in  input  1  downstream took data_out; sampled only while ready_out is high.

Function
REQ-016 States SHALL be IDLE, ACK, SEND and GAP; GAP is reachable only when BUBBLE=1.
REQ-017 IDLE: all handshake outputs low; ready_in=1 -> ACK.
REQ-018 ACK (one cycle): accepted_out=1; data_in captured into the hold register at the closing edge; slice_idx cleared to 0; next state SEND.
REQ-019 SEND: ready_out=1; data_out = slice slice_idx, taken from the top of the word when MSB_FIRST=1 and from bits [OUT_W-1:0] upward when 0.
REQ-020 SEND with accepted_in=0: hold state; data_out, slice_idx and last_out stable.
REQ-021 SEND with accepted_in=1 and slice_idx<N-1: slice_idx increments; next state SEND (BUBBLE=0) or GAP (BUBBLE=1).
REQ-022 GAP (one cycle): ready_out=0, accepted_in ignored, next state SEND.
REQ-023 SEND with accepted_in=1 and slice_idx=N-1: ready_in=1 -> ACK (back-to-back, no IDLE cycle); otherwise -> IDLE; slice_idx wraps to 0.
REQ-024 Latency: ready_in rising in IDLE -> accepted_out on the next cycle -> first ready_out on the cycle after that.
REQ-025 Throughput with BUBBLE=0 and continuous traffic: one word per N+1 cycles.
REQ-026 accepted_in outside SEND SHALL have no effect.
REQ-027 A ready_in change outside IDLE, or outside the final SEND accept, SHALL have no effect.
REQ-028 The hold register changes only in ACK; data_out is 0 whenever the hold register is 0 after reset.

Reset
REQ-029 rst=1 forces IDLE, hold register 0 and slice_idx 0; accepted_out, ready_out and last_out are 0 immediately, independent of clk.
REQ-030 Reset mid-word discards the remaining slices; after release the block waits for ready_in.

Structure
REQ-031 Package handshake_pkg SHALL hold the state enum typedef (IDLE, ACK, SEND, GAP) and the default parameter constants.
REQ-032 One sub-module, hs_slice_counter: mod-N counter with enable, clear and terminal-count output, asynchronous reset.
REQ-033 The controller FSM and the datapath (hold register, slice mux) SHALL be separate always blocks in handshake_serializer.

Verification
REQ-034 Defaults, data_in=16'hA55A, accepted_in tied high -> accepted_out pulse, then data_out 8'hA5 then 8'h5A on consecutive cycles; last_out high with 8'h5A.
REQ-035 MSB_FIRST=0, IN_W=32, data_in=32'h11223344 -> 8'h44, 8'h33, 8'h22, 8'h11; slice_idx 0..3.
REQ-036 Downstream stall: accepted_in low 5 cycles on slice 0 -> ready_out held and data_out stable at 8'hA5; then normal completion.
REQ-037 Back-to-back: ready_in high with 16'h1234 then 16'hABCD -> 8'h12, 8'h34, ACK, 8'hAB, 8'hCD with no IDLE cycle; 6 cycles from first ACK to last accept.
REQ-038 BUBBLE=1, 16'hA55A -> ready_out high, low for 1 cycle, high; accepted_in pulsed during the gap is ignored.
REQ-039 rst asserted mid-word after slice 0 -> outputs 0 asynchronously; after release no slice is emitted until a new ready_in.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared types and default parameter values for the handshake serializer.
package handshake_pkg;
  typedef enum logic [1:0] {IDLE, ACK, SEND, GAP} state_t;

  localparam int DEF_IN_W      = 16;
  localparam int DEF_OUT_W     = 8;
  localparam int DEF_MSB_FIRST = 1;
  localparam int DEF_BUBBLE    = 0;
endpackage

// File: rtl/hs_slice_counter.sv
// Mod-N slice counter with clear, enable and terminal-count flag.
module hs_slice_counter #(
  parameter int N  = 2,
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  assign tc = (cnt == CW'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/handshake_serializer.sv
// Captures a wide word from upstream and emits it as N narrow slices,
// with a ready/accepted handshake on both sides.
module handshake_serializer import handshake_pkg::*; #(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int MSB_FIRST = DEF_MSB_FIRST,
  parameter int BUBBLE    = DEF_BUBBLE,
  localparam int N        = IN_W / OUT_W,
  localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             accepted_out,
  output logic             ready_out,
  output logic [OUT_W-1:0] data_out,
  output logic             last_out,
  output logic [CW-1:0]    slice_idx,
  input  logic             accepted_in
);
  if ((IN_W % OUT_W) != 0 || N < 2) begin : g_bad_params
    $error("handshake_serializer: IN_W must be a multiple of OUT_W with at least 2 slices");
  end

  state_t          state, state_nx;
  logic            cnt_clr, cnt_en, cnt_tc;
  logic [IN_W-1:0] hold;

  hs_slice_counter #(.N(N), .CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (slice_idx),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    state_nx     = state;
    accepted_out = 1'b0;
    ready_out    = 1'b0;
    last_out     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state)
      IDLE: if (ready_in) state_nx = ACK;
      ACK: begin
        accepted_out = 1'b1;
        cnt_clr      = 1'b1;
        state_nx     = SEND;
      end
      SEND: begin
        ready_out = 1'b1;
        last_out  = cnt_tc;
        if (accepted_in) begin
          cnt_en = 1'b1;
          if (cnt_tc)           state_nx = ready_in ? ACK : IDLE;
          else if (BUBBLE != 0) state_nx = GAP;
        end
      end
      GAP:     state_nx = SEND;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               hold <= '0;
    else if (state == ACK) hold <= data_in;
  end

  // Slice position inside the hold word, given the transmission order.
  always_comb begin
    int sel;
    sel      = (MSB_FIRST != 0) ? (N - 1 - int'(slice_idx)) : int'(slice_idx);
    data_out = hold[sel*OUT_W +: OUT_W];
  end
endmodule

// File: tb/tb_handshake_serializer.sv
// Scoreboard bench: three serializer configurations, directed words,
// expected slices queued at stimulus time and checked by per-DUT monitors.
module tb_handshake_serializer;
  typedef struct {
    logic [31:0] d;
    int          idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // defaults: 16 -> 2x8, MSB first, no bubble
  logic        rdy_in0 = 1'b0, acc_in0 = 1'b0, acc_out0, ro0, last0;
  logic [15:0] d0 = '0;
  logic [7:0]  dout0;
  logic [0:0]  idx0;
  // 32 -> 4x8, LSB first
  logic        rdy_in1 = 1'b0, acc_in1 = 1'b0, acc_out1, ro1, last1;
  logic [31:0] d1 = '0;
  logic [7:0]  dout1;
  logic [1:0]  idx1;
  // 16 -> 2x8 with bubble
  logic        rdy_in2 = 1'b0, acc_in2 = 1'b0, acc_out2, ro2, last2;
  logic [15:0] d2 = '0;
  logic [7:0]  dout2;
  logic [0:0]  idx2;

  handshake_serializer u0 (
    .clk(clk), .rst(rst), .ready_in(rdy_in0), .data_in(d0), .accepted_out(acc_out0),
    .ready_out(ro0), .data_out(dout0), .last_out(last0), .slice_idx(idx0), .accepted_in(acc_in0));

  handshake_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0), .BUBBLE(0)) u1 (
    .clk(clk), .rst(rst), .ready_in(rdy_in1), .data_in(d1), .accepted_out(acc_out1),
    .ready_out(ro1), .data_out(dout1), .last_out(last1), .slice_idx(idx1), .accepted_in(acc_in1));

  handshake_serializer #(.IN_W(16), .OUT_W(8), .MSB_FIRST(1), .BUBBLE(1)) u2 (
    .clk(clk), .rst(rst), .ready_in(rdy_in2), .data_in(d2), .accepted_out(acc_out2),
    .ready_out(ro2), .data_out(dout2), .last_out(last2), .slice_idx(idx2), .accepted_in(acc_in2));

  exp_t q0[$], q1[$], q2[$];
  int   last_cyc0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_slice(input string nm, input logic [31:0] ad, input int ai,
                           input logic al, input exp_t e);
    tests++;
    if (ad !== e.d || ai != e.idx || al !== e.last) begin
      fails++;
      $display("FAIL %s slice: got data %h idx %0d last %b expected data %h idx %0d last %b",
               nm, ad, ai, al, e.d, e.idx, e.last);
    end
  endtask

  task automatic no_exp(input string nm, input logic [31:0] ad);
    tests++;
    fails++;
    $display("FAIL %s unexpected slice: got data %h expected none", nm, ad);
  endtask

  function automatic exp_t mk(input logic [31:0] d, input int idx, input logic last);
    exp_t e;
    e.d = d; e.idx = idx; e.last = last;
    return e;
  endfunction

  // Monitors: every cycle with ready_out high must show the queue head;
  // the head is retired only when downstream accepts it.
  always @(negedge clk) if (!rst && ro0) begin
    if (q0.size() == 0) no_exp("u0", {24'b0, dout0});
    else begin
      cmp_slice("u0", {24'b0, dout0}, int'(idx0), last0, q0[0]);
      if (acc_in0) begin
        void'(q0.pop_front());
        if (last0) last_cyc0 = cyc;
      end
    end
  end

  always @(negedge clk) if (!rst && ro1) begin
    if (q1.size() == 0) no_exp("u1", {24'b0, dout1});
    else begin
      cmp_slice("u1", {24'b0, dout1}, int'(idx1), last1, q1[0]);
      if (acc_in1) void'(q1.pop_front());
    end
  end

  always @(negedge clk) if (!rst && ro2) begin
    if (q2.size() == 0) no_exp("u2", {24'b0, dout2});
    else begin
      cmp_slice("u2", {24'b0, dout2}, int'(idx2), last2, q2[0]);
      if (acc_in2) void'(q2.pop_front());
    end
  end

  // Present a word on u0, wait (bounded) for the ACK, drop ready_in after it.
  task automatic send0(input logic [15:0] w, output int ackc);
    int raise_c;
    bit found;
    found = 0;
    ackc  = 0;
    @(posedge clk); #1;
    rdy_in0 = 1'b1; d0 = w; raise_c = cyc;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1;
      if (acc_out0) begin found = 1; ackc = cyc; end
    end
    chk("u0 ack seen", 32'(found), 32'd1);
    chk("u0 ack latency", 32'(ackc - raise_c), 32'd1);
    @(posedge clk); #1;
    rdy_in0 = 1'b0;
    chk("u0 first ready_out latency", 32'(ro0), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("queues drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int a1, a2;
    bit found;
    #2;
    chk("reset accepted_out", 32'(acc_out0), 32'd0);
    chk("reset ready_out", 32'(ro0), 32'd0);
    chk("reset last_out", 32'(last0), 32'd0);
    chk("reset slice_idx", 32'(idx0), 32'd0);
    chk("reset data_out", 32'(dout0), 32'd0);
    chk("reset u1 ready_out", 32'(ro1), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // basic word, downstream always ready
    q0.push_back(mk(32'hA5, 0, 1'b0));
    q0.push_back(mk(32'h5A, 1, 1'b1));
    acc_in0 = 1'b1;
    send0(16'hA55A, a1);
    drain();
    chk("u0 slices on consecutive cycles", 32'(last_cyc0 - a1), 32'd2);

    // LSB-first, four slices
    q1.push_back(mk(32'h44, 0, 1'b0));
    q1.push_back(mk(32'h33, 1, 1'b0));
    q1.push_back(mk(32'h22, 2, 1'b0));
    q1.push_back(mk(32'h11, 3, 1'b1));
    acc_in1 = 1'b1;
    @(posedge clk); #1;
    rdy_in1 = 1'b1; d1 = 32'h11223344;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1;
      if (acc_out1) found = 1;
    end
    chk("u1 ack seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    rdy_in1 = 1'b0;
    drain();

    // downstream stall on slice 0
    q0.push_back(mk(32'hA5, 0, 1'b0));
    q0.push_back(mk(32'h5A, 1, 1'b1));
    acc_in0 = 1'b0;
    send0(16'hA55A, a1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall ready_out held", 32'(ro0), 32'd1);
      chk("stall data_out stable", 32'(dout0), 32'hA5);
    end
    acc_in0 = 1'b1;
    drain();

    // back-to-back words with no idle cycle in between
    q0.push_back(mk(32'h12, 0, 1'b0));
    q0.push_back(mk(32'h34, 1, 1'b1));
    q0.push_back(mk(32'hAB, 0, 1'b0));
    q0.push_back(mk(32'hCD, 1, 1'b1));
    acc_in0 = 1'b1;
    @(posedge clk); #1;
    rdy_in0 = 1'b1; d0 = 16'h1234;
    a1 = 0; a2 = 0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1;
      if (acc_out0) begin found = 1; a1 = cyc; end
    end
    @(posedge clk); #1;
    d0 = 16'hABCD;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1;
      if (acc_out0) begin found = 1; a2 = cyc; end
    end
    chk("b2b second ack seen", 32'(found), 32'd1);
    chk("b2b ack spacing", 32'(a2 - a1), 32'd3);
    @(posedge clk); #1;
    rdy_in0 = 1'b0;
    drain();
    chk("b2b first ack to last accept", 32'(last_cyc0 - a1 + 1), 32'd6);

    // bubble pacing; accepted_in stays high through the gap and is ignored
    q2.push_back(mk(32'hA5, 0, 1'b0));
    q2.push_back(mk(32'h5A, 1, 1'b1));
    acc_in2 = 1'b1;
    @(posedge clk); #1;
    rdy_in2 = 1'b1; d2 = 16'hA55A;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1;
      if (acc_out2) found = 1;
    end
    chk("u2 ack seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    rdy_in2 = 1'b0;
    chk("bubble slice0 ready_out", 32'(ro2), 32'd1);
    @(posedge clk); #1;
    chk("bubble gap ready_out", 32'(ro2), 32'd0);
    @(posedge clk); #1;
    chk("bubble slice1 ready_out", 32'(ro2), 32'd1);
    chk("bubble slice1 idx", 32'(idx2), 32'd1);
    chk("bubble slice1 data", 32'(dout2), 32'h5A);
    acc_in2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bubble slice1 held", 32'(dout2), 32'h5A);
    acc_in2 = 1'b1;
    drain();

    // asynchronous reset mid-word, after slice 0 was taken
    q0.push_back(mk(32'hA5, 0, 1'b0));
    q0.push_back(mk(32'h5A, 1, 1'b1));
    acc_in0 = 1'b0;
    send0(16'hA55A, a1);
    acc_in0 = 1'b1;
    @(posedge clk); #1;
    acc_in0 = 1'b0;
    chk("pre-reset slice_idx", 32'(idx0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset ready_out", 32'(ro0), 32'd0);
    chk("async reset last_out", 32'(last0), 32'd0);
    chk("async reset accepted_out", 32'(acc_out0), 32'd0);
    chk("async reset slice_idx", 32'(idx0), 32'd0);
    chk("async reset data_out", 32'(dout0), 32'd0);
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    acc_in0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post-reset idle ready_out", 32'(ro0), 32'd0);
    end
    q0.push_back(mk(32'h0F, 0, 1'b0));
    q0.push_back(mk(32'hF0, 1, 1'b1));
    send0(16'h0FF0, a1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
